// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Trial subtraction uses chained 4-bit carry-skip segments (A + ~B + 1).
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int unsigned SEGS = WIDTH / 4;
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             dz;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   nb;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   next_rem;
    logic [WIDTH-1:0] next_q;

    logic             c;
    logic             seg_cin;
    logic             p;
    logic             p_all;
    int unsigned      idx;

    assign shifted  = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    assign nb       = ~{1'b0, dvs};
    assign next_rem = borrow ? shifted : diff;
    assign next_q   = {dvd[WIDTH-2:0], ~borrow};

    // A segment whose bits all propagate forwards its carry-in unchanged (skip path).
    always_comb begin
        c       = 1'b1;
        seg_cin = 1'b0;
        p       = 1'b0;
        p_all   = 1'b0;
        idx     = 0;
        diff    = '0;
        for (int unsigned s = 0; s < SEGS; s++) begin
            seg_cin = c;
            p_all   = 1'b1;
            for (int unsigned b = 0; b < 4; b++) begin
                idx       = 4 * s + b;
                p         = shifted[idx] ^ nb[idx];
                diff[idx] = p ^ c;
                c         = (shifted[idx] & nb[idx]) | (p & c);
                p_all     = p_all & p;
            end
            if (p_all) begin
                c = seg_cin;
            end
        end
        p           = shifted[WIDTH] ^ nb[WIDTH];
        diff[WIDTH] = p ^ c;
        c           = (shifted[WIDTH] & nb[WIDTH]) | (p & c);
        borrow      = ~c;
    end

    // Divide-by-zero spends one RUN cycle so o_done lands one cycle after the start edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            rem           <= '0;
            dvd           <= '0;
            dvs           <= '0;
            cnt           <= '0;
            dz            <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= RUN;
                        o_busy <= 1'b1;
                        dvd    <= i_dividend;
                        dvs    <= i_divisor;
                        rem    <= '0;
                        if (i_divisor == '0) begin
                            dz  <= 1'b1;
                            cnt <= '0;
                        end else begin
                            dz  <= 1'b0;
                            cnt <= CW'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    if (dz) begin
                        state         <= DONE;
                        o_done        <= 1'b1;
                        o_quotient    <= '1;
                        o_remainder   <= dvd;
                        o_div_by_zero <= 1'b1;
                    end else begin
                        rem <= next_rem;
                        dvd <= next_q;
                        if (cnt == '0) begin
                            state         <= DONE;
                            o_done        <= 1'b1;
                            o_quotient    <= next_q;
                            o_remainder   <= next_rem[WIDTH-1:0];
                            o_div_by_zero <= 1'b0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=8): latency, results,
// busy/done timing, start-while-busy, divide-by-zero and mid-run reset.
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dz;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_dividend   (dividend),
        .i_divisor    (divisor),
        .o_busy       (busy),
        .o_done       (done),
        .o_quotient   (quotient),
        .o_remainder  (remainder),
        .o_div_by_zero(dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a division and follow it until busy drops; operands are scrambled after acceptance.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int lat, input logic [7:0] eq, input logic [7:0] er,
                           input logic edz, input bit poke);
        int   done_at;
        int   busy_n;
        int   done_n;
        bit   fin;
        logic [7:0] gq;
        logic [7:0] gr;
        logic gdz;
        done_at = -1;
        busy_n  = 0;
        done_n  = 0;
        fin     = 1'b0;
        gq      = 8'h00;
        gr      = 8'h00;
        gdz     = 1'b0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        for (int t = 0; t < 40 && !fin; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (poke && t == 3) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd3;
            end
            if (poke && t == 4) start = 1'b0;
            if (busy) busy_n++;
            else begin
                fin   = 1'b1;
                start = 1'b0;
            end
            if (done) begin
                done_n++;
                done_at = t;
                gq  = quotient;
                gr  = remainder;
                gdz = dz;
                if (poke) begin
                    start    = 1'b1;
                    dividend = 8'd9;
                    divisor  = 8'd3;
                end
            end
        end
        chk({tag, ".idle"},    32'(fin), 32'd1);
        chk({tag, ".latency"}, 32'(done_at), 32'(lat));
        chk({tag, ".busy"},    32'(busy_n), 32'(lat + 1));
        chk({tag, ".pulses"},  32'(done_n), 32'd1);
        chk({tag, ".q"},       32'(gq), 32'(eq));
        chk({tag, ".r"},       32'(gr), 32'(er));
        chk({tag, ".dz"},      32'(gdz), 32'(edz));
        chk({tag, ".hold_q"},  32'(quotient), 32'(eq));
    endtask

    initial begin
        bit         seen_done;
        logic [7:0] ra;
        logic [7:0] rb;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.q",    32'(quotient), 32'd0);
        chk("rst.r",    32'(remainder), 32'd0);
        chk("rst.dz",   32'(dz), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("d100_7",   8'd100, 8'd7,   8, 8'd14,  8'd2,  1'b0, 1'b0);
        run_div("d255_1",   8'd255, 8'd1,   8, 8'd255, 8'd0,  1'b0, 1'b0);
        run_div("d5_9",     8'd5,   8'd9,   8, 8'd0,   8'd5,  1'b0, 1'b0);
        run_div("d200_200", 8'd200, 8'd200, 8, 8'd1,   8'd0,  1'b0, 1'b0);
        run_div("d254_16",  8'd254, 8'd16,  8, 8'd15,  8'd14, 1'b0, 1'b0);
        run_div("d128_3",   8'd128, 8'd3,   8, 8'd42,  8'd2,  1'b0, 1'b0);
        run_div("d0_1",     8'd0,   8'd1,   8, 8'd0,   8'd0,  1'b0, 1'b0);
        run_div("d37_0",    8'd37,  8'd0,   1, 8'hFF,  8'd37, 1'b1, 1'b0);
        run_div("d37_5",    8'd37,  8'd5,   8, 8'd7,   8'd2,  1'b0, 1'b0);
        run_div("poke",     8'd100, 8'd7,   8, 8'd14,  8'd2,  1'b0, 1'b1);
        run_div("d9_3",     8'd9,   8'd3,   8, 8'd3,   8'd0,  1'b0, 1'b0);

        // Reset during the fourth iteration of 100/7.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.q",    32'(quotient), 32'd0);
        chk("abort.r",    32'(remainder), 32'd0);
        chk("abort.dz",   32'(dz), 32'd0);
        seen_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        chk("abort.no_done", 32'(seen_done), 32'd0);
        run_div("d50_6", 8'd50, 8'd6, 8, 8'd8, 8'd2, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            run_div("rand", ra, rb, 8, ra / rb, ra % rb, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
